// File: rtl/rv_dp.sv
// Multicycle RISC-V datapath: PC/PCC/IR/A/B/ALUOut/MDR/DataW plus 32x32 regfile, stepped by control strobes.
// Latency: every strobe lands on the next posedge; instr/zero/imem/dmem outputs are combinational. No backpressure.
module rv_dp #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] instr,
    output logic            zero,
    input  logic            pcsourse,
    input  logic            pcwrite,
    input  logic            pccen,
    input  logic            irwrite,
    input  logic [1:0]      wbsel,
    input  logic            regwen,
    input  logic [1:0]      immsel,
    input  logic [1:0]      asel,
    input  logic            bsel,
    input  logic [3:0]      alusel,
    input  logic            mdrwrite,
    input  logic            datawregen,
    input  logic            datawsel,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata
);
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd0;
    localparam logic [1:0] IMM_S     = 2'd1;
    localparam logic [1:0] IMM_B     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd3;
    localparam logic [1:0] ALUA_PCC  = 2'd1;
    localparam logic [1:0] ALUA_ZERO = 2'd2;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [XLEN-1:0] pc, pcc, ir, a, b, alu_out, mdr, dataw;
    logic [XLEN-1:0] rf [32];
    logic [4:0]      rs1, rs2, rd, shamt;
    logic [XLEN-1:0] rs1_val, rs2_val, imm, alu_a, alu_b, alu_res, pc_next, wb_data;
    logic            is_jal;

    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign rd      = ir[11:7];
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

    always_comb begin
        imm = '0;
        case (immsel)
            IMM_L:   imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        alu_a = a;
        case (asel)
            ALUA_PCC:  alu_a = pcc;
            ALUA_ZERO: alu_a = '0;
            default:   alu_a = a;
        endcase
    end

    assign alu_b = bsel ? imm : b;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = '0;
        case (alusel)
            4'b0000: alu_res = alu_a + alu_b;
            4'b0001: alu_res = alu_a - alu_b;
            4'b0010: alu_res = alu_a << shamt;
            4'b0100: alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            4'b0110: alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
            4'b1000: alu_res = alu_a ^ alu_b;
            4'b1010: alu_res = alu_a >> shamt;
            4'b1011: alu_res = $signed(alu_a) >>> shamt;
            4'b1100: alu_res = alu_a | alu_b;
            4'b1110: alu_res = alu_a & alu_b;
            default: alu_res = '0;
        endcase
    end

    assign zero = (alu_res == '0);

    // JAL resolves its target in the exec cycle itself; branches reuse the target latched in decode.
    assign is_jal  = (ir[6:0] == OP_JAL);
    assign pc_next = pcsourse ? (is_jal ? alu_res : alu_out) : pc + XLEN'(4);

    always_comb begin
        wb_data = alu_out;
        case (wbsel)
            WB_MDR:  wb_data = mdr;
            WB_PC:   wb_data = pc;
            default: wb_data = alu_out;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            pcc     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            dataw   <= '0;
        end else begin
            if (pcwrite)    pc    <= pc_next;
            if (pccen)      pcc   <= pc;
            if (irwrite)    ir    <= imem_rdata;
            if (mdrwrite)   mdr   <= dmem_rdata;
            if (datawregen) dataw <= alu_res;
            a       <= rs1_val;
            b       <= rs2_val;
            alu_out <= alu_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (regwen && rd != 5'd0) begin
            rf[rd] <= wb_data;
        end
    end

    assign instr      = ir;
    assign imem_addr  = pc;
    assign dmem_addr  = alu_out;
    assign dmem_wdata = datawsel ? dataw : b;
endmodule

// File: tb/tb_rv_dp.sv
// Bench for rv_dp: directed multicycle sequences plus randomized ALU ops against an instruction-level model.
module tb_rv_dp;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        zero, pcsourse, pcwrite, pccen, irwrite, regwen, bsel, mdrwrite, datawregen, datawsel;
    logic [1:0]  wbsel, immsel, asel;
    logic [3:0]  alusel;

    logic [31:0] mrf [32];
    int          n_err, n_chk;

    rv_dp #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
        .alusel(alusel), .mdrwrite(mdrwrite), .datawregen(datawregen), .datawsel(datawsel),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            4'b0000: return x + y;
            4'b0001: return x - y;
            4'b0010: return x << y[4:0];
            4'b0100: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0110: return (x < y) ? 32'd1 : 32'd0;
            4'b1000: return x ^ y;
            4'b1010: return x >> y[4:0];
            4'b1011: return 32'($signed(x) >>> y[4:0]);
            4'b1100: return x | y;
            4'b1110: return x & y;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        pcsourse = 0; pcwrite = 0; pccen = 0; irwrite = 0; wbsel = 0; regwen = 0;
        immsel = 0; asel = 0; bsel = 0; alusel = 0; mdrwrite = 0; datawregen = 0; datawsel = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] word);
        idle(); irwrite = 1; imem_rdata = word; tick(); idle();
    endtask

    task automatic fetch(input logic [31:0] word);
        idle(); irwrite = 1; pcwrite = 1; pccen = 1; imem_rdata = word; tick(); idle();
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        load_ir({20'h0, r, 7'h13});
        mdrwrite = 1; dmem_rdata = v; tick(); idle();
        regwen = 1; wbsel = 2'd1; tick(); idle();
        if (r != 5'd0) mrf[r] = v;
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        load_ir({7'h0, r, 20'h00013});
        tick();
        v = dmem_wdata;
    endtask

    task automatic set_pc(input logic [31:0] t);
        load_ir({t[11:0], 20'h00013});
        asel = 2'd2; bsel = 1; immsel = 2'd0; alusel = 4'd0; tick(); idle();
        pcsourse = 1; pcwrite = 1; tick(); idle();
    endtask

    task automatic run_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [3:0] op, input logic use_imm, input logic [11:0] imm,
                          input logic [1:0] av, input logic [1:0] wv);
        logic [31:0] opb, exp, got, word;
        opb  = use_imm ? {{20{imm[11]}}, imm} : mrf[rs2];
        exp  = alu_ref(op, mrf[rs1], opb);
        word = use_imm ? {imm, rs1, 3'b000, rd, 7'h13} : {7'h0, rs2, rs1, 3'b000, rd, 7'h33};
        fetch(word);
        tick();
        asel = av; bsel = use_imm; immsel = 2'd0; alusel = op;
        #1;
        chk($sformatf("zero_op%0h", op), 32'(zero), 32'(exp == 32'd0));
        tick(); idle();
        regwen = 1; wbsel = wv; tick(); idle();
        if (rd != 5'd0) mrf[rd] = exp;
        read_reg(rd, got);
        chk($sformatf("alu_op%0h_x%0d", op, rd), got, mrf[rd]);
    endtask

    initial begin
        logic [31:0] v, v1, v2, word;
        logic [4:0]  r1, r2, rdst;
        logic        ez;
        n_err = 0; n_chk = 0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        idle(); imem_rdata = 0; dmem_rdata = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", instr, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_zero", 32'(zero), 32'd1);
        rst = 0;
        tick();

        // lw x5,8(x0) interrupted by reset in its memory cycle
        fetch(32'h0080_2283);
        chk("lw_fetch_pc", imem_addr, 32'h4);
        tick();
        bsel = 1; tick(); idle();
        chk("lw_addr", dmem_addr, 32'h8);
        mdrwrite = 1; dmem_rdata = 32'h1234_5678;
        #1 rst = 1;
        #1;
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_pc", imem_addr, 32'h0);
        tick(); idle(); rst = 0;
        tick();
        chk("midrst_pc_next", imem_addr, 32'h0);
        read_reg(5'd5, v);
        chk("midrst_x5", v, mrf[5]);

        // add x4,x5,x6 fetched at 0x10
        write_reg(5'd5, 32'd7);
        write_reg(5'd6, -32'sd3);
        set_pc(32'h10);
        chk("setpc_0x10", imem_addr, 32'h10);
        fetch(32'h0062_8233);
        chk("add_instr", instr, 32'h0062_8233);
        chk("add_pc", imem_addr, 32'h14);
        asel = 2'd1; bsel = 1; immsel = 2'd0; tick(); idle();
        chk("add_pcc_imm", dmem_addr, 32'h16);
        #1;
        chk("add_zero", 32'(zero), 32'd0);
        tick(); idle();
        regwen = 1; tick(); idle();
        mrf[4] = 32'd4;
        read_reg(5'd4, v);
        chk("add_x4", v, mrf[4]);

        // beq x1,x2,+0x20 at 0x40: taken, then not taken
        write_reg(5'd1, 32'd9);
        write_reg(5'd2, 32'd9);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) write_reg(5'd2, 32'd8);
            set_pc(32'h40);
            fetch(32'h0220_8063);
            asel = 2'd1; bsel = 1; immsel = 2'd2; tick(); idle();
            chk("beq_target", dmem_addr, 32'h60);
            alusel = 4'b0001;
            #1;
            ez = (mrf[1] == mrf[2]);
            chk("beq_zero", 32'(zero), 32'(ez));
            pcsourse = 1; pcwrite = ez; tick(); idle();
            chk("beq_pc", imem_addr, ez ? 32'h60 : 32'h44);
        end

        // jal rd,-8 at 0x100 with rd=x1 then rd=x0
        for (int k = 0; k < 2; k++) begin
            rdst = (k == 0) ? 5'd1 : 5'd0;
            word = {20'hFF9FF, rdst, 7'h6F};
            set_pc(32'h100);
            fetch(word);
            tick();
            asel = 2'd1; bsel = 1; immsel = 2'd3; pcwrite = 1; pcsourse = 1; regwen = 1; wbsel = 2'd2;
            tick(); idle();
            chk("jal_pc", imem_addr, 32'hF8);
            if (rdst != 5'd0) mrf[rdst] = 32'h104;
            read_reg(rdst, v);
            chk($sformatf("jal_rd_x%0d", rdst), v, mrf[rdst]);
        end

        // sw x7,4(x3) and lw x8,-4(x3)
        write_reg(5'd3, 32'h200);
        write_reg(5'd7, 32'hA5A5_1234);
        fetch(32'h0071_A223);
        tick();
        bsel = 1; immsel = 2'd1; tick(); idle();
        chk("sw_addr", dmem_addr, 32'h204);
        chk("sw_wdata", dmem_wdata, mrf[7]);
        fetch(32'hFFC1_A403);
        tick();
        bsel = 1; immsel = 2'd0; tick(); idle();
        chk("lw_addr_neg", dmem_addr, 32'h1FC);
        mdrwrite = 1; dmem_rdata = 32'hDEAD_BEEF; tick(); idle();
        regwen = 1; wbsel = 2'd1; tick(); idle();
        mrf[8] = 32'hDEAD_BEEF;
        read_reg(5'd8, v);
        chk("lw_x8", v, mrf[8]);

        // DataW path: 0 - x7 held in DataW and selected onto store data
        write_reg(5'd7, 32'd5);
        load_ir(32'h0071_A223);
        tick();
        asel = 2'd2; alusel = 4'b0001; datawregen = 1; tick(); idle();
        datawsel = 1;
        #1 chk("dataw_sel1", dmem_wdata, 32'hFFFF_FFFB);
        datawsel = 0;
        #1 chk("dataw_sel0", dmem_wdata, 32'd5);
        tick();
        datawsel = 1;
        #1 chk("dataw_hold", dmem_wdata, 32'hFFFF_FFFB);
        idle();

        write_reg(5'd9, 32'h8000_0000);
        write_reg(5'd10, 32'd31);
        run_op(5'd9, 5'd10, 5'd11, 4'b1011, 1'b0, 12'h0, 2'd0, 2'd0);

        for (int i = 0; i < 40; i++) begin
            r1   = 5'($urandom_range(1, 31));
            r2   = 5'($urandom_range(1, 31));
            rdst = 5'($urandom_range(1, 31));
            v1   = $urandom;
            case ($urandom_range(0, 2))
                0:       v2 = v1;
                1:       v2 = 32'($urandom_range(0, 31));
                default: v2 = $urandom;
            endcase
            write_reg(r1, v1);
            write_reg(r2, v2);
            run_op(r1, r2, rdst, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   12'($urandom), ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0,
                   ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
